bus_mm: RTL and testbench

- Parametrised multi-master, multi-slave shared bus. Successor to the single-master two-slave BUS block used by the factorial calculator datapath.
- Arbitrates N_MASTERS requesters with round-robin fairness and an optional hold limit.
- Decodes the granted master's address against per-slave base/mask windows and drives one slave select.
- Returns registered read data with a decode-error flag aligned to that data.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_rr_arb.sv | 112 +++++++++++
 rtl/bus_mm.sv | 96 +++++++++
 tb/tb_bus_mm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the multi-master bus: default address map,
// structural limits and a constant-evaluable clog2.
package bus_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_SLAVES  = 8;

    localparam logic [15:0] SLV0_BASE = 16'h0000;
    localparam logic [15:0] SLV0_MASK = 16'hF800;
    localparam logic [15:0] SLV1_BASE = 16'h7000;
    localparam logic [15:0] SLV1_MASK = 16'hFE00;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_rr_arb.sv
// Round-robin bus arbiter with optional hold limit; owns the rotation
// pointer, the hold counter and the registered one-hot grant.
module bus_rr_arb
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int MAX_HOLD  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] grant
);

    localparam int IDX_W    = (N_MASTERS > 1) ? clog2(N_MASTERS) : 1;
    localparam int HOLD_W   = clog2(MAX_HOLD) + 1;
    localparam int HOLD_TOP = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    typedef enum logic {IDLE, OWNED} arb_state_t;

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     pick;
    logic                 found;
    logic                 owner_req;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        if (int'(v) >= HOLD_TOP) return HOLD_W'(HOLD_TOP);
        return v + 1'b1;
    endfunction

    // From IDLE the search starts after the pointer and may wrap onto it;
    // from OWNED it starts after the owner and never returns the owner.
    always_comb begin
        int base;
        int last;
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        base  = (state_q == IDLE) ? int'(ptr_q) : int'(owner_q);
        last  = (state_q == IDLE) ? N_MASTERS : N_MASTERS - 1;
        for (int off = 1; off <= N_MASTERS; off++) begin
            idx = base + off;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!found && off <= last && |(req & (N_MASTERS'(1) << idx))) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    assign owner_req = |(req & (N_MASTERS'(1) << owner_q));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWNED;
                    owner_d = pick;
                    ptr_d   = pick;
                    hold_d  = '0;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    hold_d = '0;
                    if (found) begin
                        owner_d = pick;
                        ptr_d   = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (MAX_HOLD != 0 && int'(hold_q) == HOLD_TOP && found) begin
                    owner_d = pick;
                    ptr_d   = pick;
                    hold_d  = '0;
                end else begin
                    hold_d = sat_inc(hold_q);
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == OWNED) ? (N_MASTERS'(1) << owner_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(N_MASTERS - 1);
            hold_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: rtl/bus_mm.sv
// Multi-master, multi-slave shared bus: arbitration, window decode,
// granted-master mux and a one-cycle registered read return.
module bus_mm
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {SLV1_BASE, SLV0_BASE},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {SLV1_MASK, SLV0_MASK},
    parameter int MAX_HOLD  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_wr,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_dout,
    input  logic [N_SLAVES*DATA_W-1:0]    s_dout,
    output logic [N_MASTERS-1:0]          m_grant,
    output logic [DATA_W-1:0]             m_din,
    output logic                          m_err,
    output logic [N_SLAVES-1:0]           s_sel,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_wr,
    output logic [DATA_W-1:0]             s_din
);

    logic                vld_p0;
    logic                hit_any;
    logic                dec_err;
    logic [N_SLAVES-1:0] rd_sel_p1;
    logic                rd_err_p1;

    bus_rr_arb #(
        .N_MASTERS (N_MASTERS),
        .MAX_HOLD  (MAX_HOLD)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (m_req),
        .grant (m_grant)
    );

    assign vld_p0 = |m_grant;

    // Stage p0: grant is one-hot, so OR-ing gated fields selects the owner.
    always_comb begin
        s_addr = '0;
        s_wr   = 1'b0;
        s_din  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (m_grant[i]) begin
                s_addr = s_addr | m_addr[i*ADDR_W +: ADDR_W];
                s_wr   = s_wr | m_wr[i];
                s_din  = s_din | m_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        s_sel   = '0;
        hit_any = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!hit_any &&
                ((s_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
                hit_any  = 1'b1;
                s_sel[i] = vld_p0;
            end
        end
    end

    assign dec_err = vld_p0 && !hit_any;

    // Stage p1: writes leave rd_sel empty so m_din returns zero after them.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sel_p1 <= '0;
            rd_err_p1 <= 1'b0;
        end else begin
            rd_sel_p1 <= s_sel & {N_SLAVES{~s_wr}};
            rd_err_p1 <= dec_err;
        end
    end

    always_comb begin
        m_din = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (rd_sel_p1[i]) m_din = m_din | s_dout[i*DATA_W +: DATA_W];
        end
    end

    assign m_err = rd_err_p1;

endmodule

// File: tb/tb_bus_mm.sv
// Scoreboard bench for bus_mm: two instances (unlimited hold and MAX_HOLD=4)
// share stimulus; a reference model feeds queues drained by a monitor.
module tb_bus_mm;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam logic [DW-1:0] SD0 = 64'h1111_1111;
    localparam logic [DW-1:0] SD1 = 64'h2222_2222;

    logic clk = 1'b0;
    logic reset;
    logic [NM-1:0]    m_req, m_wr;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_dout;
    logic [NS*DW-1:0] s_dout;

    logic [NM-1:0] m_grant [2];
    logic [DW-1:0] m_din   [2];
    logic          m_err   [2];
    logic [NS-1:0] s_sel   [2];
    logic [AW-1:0] s_addr  [2];
    logic          s_wr    [2];
    logic [DW-1:0] s_din   [2];

    always #5 clk = ~clk;

    bus_mm #(.MAX_HOLD(0)) u_h0 (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
        .m_dout(m_dout), .s_dout(s_dout), .m_grant(m_grant[0]), .m_din(m_din[0]),
        .m_err(m_err[0]), .s_sel(s_sel[0]), .s_addr(s_addr[0]), .s_wr(s_wr[0]),
        .s_din(s_din[0])
    );

    bus_mm #(.MAX_HOLD(4)) u_h4 (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
        .m_dout(m_dout), .s_dout(s_dout), .m_grant(m_grant[1]), .m_din(m_din[1]),
        .m_err(m_err[1]), .s_sel(s_sel[1]), .s_addr(s_addr[1]), .s_wr(s_wr[1]),
        .s_din(s_din[1])
    );

    typedef struct packed {
        logic [NM-1:0] grant;
        logic [NS-1:0] sel;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] din;
    } comb_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rd_t;

    comb_t cq0[$], cq1[$];
    rd_t   rq0[$], rq1[$];

    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b0;

    // Reference model state, one slot per instance.
    int own  [2] = '{-1, -1};
    int ptr  [2] = '{NM - 1, NM - 1};
    int hold [2] = '{0, 0};
    int mh   [2] = '{0, 4};
    bit pv   [2] = '{1'b0, 1'b0};
    int pslv [2] = '{-1, -1};
    bit pwr  [2] = '{1'b0, 1'b0};
    bit perr [2] = '{1'b0, 1'b0};
    bit prst = 1'b1;
    logic [NM-1:0] prevg [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s actual=empty-queue required=entry t=%0t", name, $time);
    endtask

    function automatic int next_req(input logic [NM-1:0] req, input int from, input bit excl);
        for (int off = 1; off <= NM; off++) begin
            int idx;
            idx = (from + off) % NM;
            if (!(excl && idx == from) && req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int decode(input logic [AW-1:0] a);
        if ((a & 16'hF800) == 16'h0000) return 0;
        if ((a & 16'hFE00) == 16'h7000) return 1;
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return AW'($urandom_range(0, 32'h07FF));
            1:       return AW'(32'h7000 + $urandom_range(0, 32'h01FF));
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic step(input logic rst, input logic [NM-1:0] req, input logic [NM-1:0] wr,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        comb_t c;
        rd_t   r;
        int    slv;
        int    nx;
        @(posedge clk);
        #1;
        reset  = rst;
        m_req  = req;
        m_wr   = wr;
        m_addr = {a1, a0};
        m_dout = {d1, d0};
        s_dout = {s1, s0};
        mon_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (pv[d]) begin
                r.err  = prst ? 1'b0 : perr[d];
                r.data = (prst || pwr[d] || pslv[d] < 0) ? '0 : ((pslv[d] == 0) ? s0 : s1);
                if (d == 0) rq0.push_back(r); else rq1.push_back(r);
            end
            c = '0;
            pv[d] = 1'b0;
            if (own[d] >= 0) begin
                c.grant = NM'(1) << own[d];
                c.addr  = (own[d] == 0) ? a0 : a1;
                c.din   = (own[d] == 0) ? d0 : d1;
                c.wr    = wr[own[d]];
                slv     = decode(c.addr);
                if (slv >= 0) c.sel = NS'(1) << slv;
                pv[d]   = 1'b1;
                pslv[d] = slv;
                pwr[d]  = c.wr;
                perr[d] = (slv < 0);
            end
            if (d == 0) cq0.push_back(c); else cq1.push_back(c);

            if (rst) begin
                own[d] = -1; ptr[d] = NM - 1; hold[d] = 0;
            end else if (own[d] < 0) begin
                nx = next_req(req, ptr[d], 1'b0);
                if (nx >= 0) begin own[d] = nx; ptr[d] = nx; hold[d] = 0; end
            end else if (!req[own[d]]) begin
                nx = next_req(req, own[d], 1'b1);
                hold[d] = 0;
                own[d]  = nx;
                if (nx >= 0) ptr[d] = nx;
            end else begin
                nx = next_req(req, own[d], 1'b1);
                if (mh[d] != 0 && hold[d] == mh[d] - 1 && nx >= 0) begin
                    own[d] = nx; ptr[d] = nx; hold[d] = 0;
                end else if (mh[d] != 0 && hold[d] < mh[d] - 1) begin
                    hold[d]++;
                end
            end
        end
        prst = rst;
    endtask

    task automatic check_dut(input int d);
        comb_t c;
        rd_t   r;
        string p;
        bit    have;
        p = (d == 0) ? "h0" : "h4";
        if (prevg[d] != '0) begin
            have = (d == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
            if (!have) begin
                fail_now({p, "_rd_queue"});
            end else begin
                if (d == 0) r = rq0.pop_front(); else r = rq1.pop_front();
                chk({p, "_m_din"}, m_din[d], r.data);
                chk({p, "_m_err"}, 64'(m_err[d]), 64'(r.err));
            end
        end else begin
            chk({p, "_m_din_idle"}, m_din[d], '0);
            chk({p, "_m_err_idle"}, 64'(m_err[d]), '0);
        end
        have = (d == 0) ? (cq0.size() > 0) : (cq1.size() > 0);
        if (!have) begin
            fail_now({p, "_comb_queue"});
        end else begin
            if (d == 0) c = cq0.pop_front(); else c = cq1.pop_front();
            chk({p, "_m_grant"}, 64'(m_grant[d]), 64'(c.grant));
            chk({p, "_s_sel"},   64'(s_sel[d]),   64'(c.sel));
            chk({p, "_s_addr"},  64'(s_addr[d]),  64'(c.addr));
            chk({p, "_s_wr"},    64'(s_wr[d]),    64'(c.wr));
            chk({p, "_s_din"},   s_din[d],        c.din);
        end
        prevg[d] = m_grant[d];
    endtask

    initial begin : monitor
        prevg[0] = '0;
        prevg[1] = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_dut(0);
                check_dut(1);
            end
        end
    end

    initial begin : driver
        logic [NM-1:0] rq;
        logic          rst;
        reset  = 1'b1;
        m_req  = '0;
        m_wr   = '0;
        m_addr = '0;
        m_dout = '0;
        s_dout = '0;
        repeat (3) @(posedge clk);

        repeat (3)  step(1'b0, 2'b01, 2'b00, 16'h0010, 16'h7010, '0, '0, SD0, SD1);
        repeat (12) step(1'b0, 2'b11, 2'b00, 16'h0010, 16'h7010, '0, '0, SD0, SD1);
        repeat (3)  step(1'b0, 2'b10, 2'b00, 16'h0010, 16'h7010, '0, '0, SD0, SD1);
        repeat (2)  step(1'b0, 2'b10, 2'b00, 16'h0010, 16'h3000, '0, '0, SD0, SD1);
        repeat (3)  step(1'b0, 2'b01, 2'b01, 16'h0010, 16'h3000, 64'd10, '0, SD0, SD1);
        step(1'b1, 2'b01, 2'b00, 16'h0010, 16'h7010, '0, '0, SD0, SD1);
        repeat (2)  step(1'b0, 2'b00, 2'b00, 16'h0010, 16'h7010, '0, '0, SD0, SD1);

        rq = '0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) rq = NM'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            step(rst, rq, NM'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 rand_addr(), rand_addr(),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom});
        end

        repeat (2) step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        #1;
        chk("h0_rd_queue_left", 64'(rq0.size()), '0);
        chk("h4_rd_queue_left", 64'(rq1.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
